max_tree_module: RTL and testbench

- Pipelined signed-max reduction front end for the tree-based softmax approximation.
- Takes one 64-lane beat of 16-bit signed fixed-point scores (10 fractional bits) per cycle.
- Produces the segment maxima of each beat (1x64, 2x32, 4x16) and a row-wide global max that can span several beats, selected by a length mode.
- Also delays the raw beat and mode so downstream exp/normalise stages receive data aligned with the maxima.

---
 rtl/max_tree_pkg.sv | 33 +++
 rtl/max_cmp2.sv | 24 ++
 rtl/max_tree_module.sv | 161 ++++++++++++++++
 tb/tb_max_tree_module.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_tree_pkg.sv
// Shared constants, mode codes, stage bundles and the signed max helper
// for the max-reduction front end.
package max_tree_pkg;

   localparam int DW     = 16;
   localparam int N      = 64;
   localparam int LAT    = 12;
   localparam int LEVELS = 6;

   localparam logic [DW-1:0] NEG_MIN = 16'h8000;

   // Codes 0..2 are single-beat rows; any code m >= 3 spans m-1 beats.
   localparam logic [3:0] MODE_ROW64 = 4'd0;
   localparam logic [3:0] MODE_ROW32 = 4'd1;
   localparam logic [3:0] MODE_ROW16 = 4'd2;

   typedef struct packed {
      logic            valid;
      logic [3:0]      mode;
      logic [N*DW-1:0] data;
   } byp_t;

   typedef struct packed {
      logic [3:0][DW-1:0] m16;
      logic [1:0][DW-1:0] m32;
      logic [DW-1:0]      m64;
   } seg_t;

   function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return ($signed(a) >= $signed(b)) ? a : b;
   endfunction

endpackage

// File: rtl/max_cmp2.sv
// One registered node of the reduction tree: y <= signed max(a, b) when enabled.
import max_tree_pkg::*;

module max_cmp2 (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] y_o
);

   logic [DW-1:0] y_q, y_d;

   assign y_d = en_i ? smax(a_i, b_i) : y_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) y_q <= '0;
      else         y_q <= y_d;
   end

   assign y_o = y_q;

endmodule

// File: rtl/max_tree_module.sv
// Pipelined signed-max reduction of a 64-lane beat with segment maxima,
// a multi-beat row accumulator, and a data/mode bypass aligned to the maxima.
import max_tree_pkg::*;

module max_tree_module (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic [3:0]      i_length_mode,
   input  logic [N-1:0]    i_valid,
   input  logic [N*DW-1:0] i_in_flat,
   output logic [DW-1:0]   o_global_max,
   output logic [DW-1:0]   o_max64_0,
   output logic [DW-1:0]   o_max32_0,
   output logic [DW-1:0]   o_max32_1,
   output logic [DW-1:0]   o_max16_0,
   output logic [DW-1:0]   o_max16_1,
   output logic [DW-1:0]   o_max16_2,
   output logic [DW-1:0]   o_max16_3,
   output logic            o_valid_max,
   output logic [3:0]      o_length_mode_byp,
   output logic [N*DW-1:0] o_in_byp
);

   // Heap-ordered tree: node i reduces nodes 2i and 2i+1; leaves sit at N..2N-1.
   logic [DW-1:0] node [1:2*N-1];

   for (genvar k = 0; k < N; k++) begin : g_leaf
      assign node[N+k] = i_valid[k] ? i_in_flat[k*DW +: DW] : NEG_MIN;
   end

   for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
      for (genvar j = 0; j < (N >> lv); j++) begin : g_cmp
         localparam int IDX = (N >> lv) + j;
         max_cmp2 u_cmp (
            .clk_i  (i_clk),
            .rst_ni (i_rst),
            .en_i   (i_en),
            .a_i    (node[2*IDX]),
            .b_i    (node[2*IDX+1]),
            .y_o    (node[IDX])
         );
      end
   end

   logic [3:0][DW-1:0] m16_d1_q, m16_d2_q;
   logic [1:0][DW-1:0] m32_d1_q;
   seg_t               seg_pipe_q [0:LAT-LEVELS-1];
   byp_t               byp_pipe_q [0:LAT-1];

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         m16_d1_q <= '0;
         m16_d2_q <= '0;
         m32_d1_q <= '0;
         for (int s = 0; s < LAT-LEVELS; s++) seg_pipe_q[s] <= '0;
         for (int s = 0; s < LAT; s++)        byp_pipe_q[s] <= '0;
      end else if (i_en) begin
         // Level-4 and level-5 results are held back until the root is ready.
         m16_d1_q      <= {node[7], node[6], node[5], node[4]};
         m16_d2_q      <= m16_d1_q;
         m32_d1_q      <= {node[3], node[2]};
         seg_pipe_q[0] <= {m16_d2_q, m32_d1_q, node[1]};
         for (int s = 1; s < LAT-LEVELS; s++) seg_pipe_q[s] <= seg_pipe_q[s-1];
         byp_pipe_q[0] <= {|i_valid, i_length_mode, i_in_flat};
         for (int s = 1; s < LAT; s++) byp_pipe_q[s] <= byp_pipe_q[s-1];
      end
   end

   byp_t tail;
   seg_t seg_tail;
   logic fire;

   assign tail     = byp_pipe_q[LAT-1];
   assign seg_tail = seg_pipe_q[LAT-LEVELS-1];
   assign fire     = i_en & tail.valid;

   logic [DW-1:0] run_q, run_d, global_d;
   logic [3:0]    cnt_q, cnt_d, last_mode_q, last_mode_d, cnt_cur;
   logic          first;

   always_comb begin
      run_d       = run_q;
      cnt_d       = cnt_q;
      last_mode_d = last_mode_q;
      global_d    = seg_tail.m64;
      first       = 1'b0;
      cnt_cur     = cnt_q;
      if (fire) begin
         last_mode_d = tail.mode;
         case (tail.mode)
            MODE_ROW64, MODE_ROW32, MODE_ROW16: begin
               run_d = NEG_MIN;
               cnt_d = '0;
            end
            default: begin
               // A mode change mid-row starts a fresh row with this beat.
               first    = (cnt_q == '0) || (tail.mode != last_mode_q);
               cnt_cur  = first ? 4'd0 : cnt_q;
               run_d    = first ? seg_tail.m64 : smax(run_q, seg_tail.m64);
               global_d = run_d;
               cnt_d    = (cnt_cur == tail.mode - 4'd2) ? 4'd0 : cnt_cur + 4'd1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         run_q       <= NEG_MIN;
         cnt_q       <= '0;
         last_mode_q <= '0;
      end else begin
         run_q       <= run_d;
         cnt_q       <= cnt_d;
         last_mode_q <= last_mode_d;
      end
   end

   logic            valid_q;
   logic [DW-1:0]   global_q, m64_q;
   logic [1:0][DW-1:0] m32_q;
   logic [3:0][DW-1:0] m16_q;
   logic [3:0]      mode_q;
   logic [N*DW-1:0] data_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         valid_q  <= 1'b0;
         global_q <= '0;
         m64_q    <= '0;
         m32_q    <= '0;
         m16_q    <= '0;
         mode_q   <= '0;
         data_q   <= '0;
      end else begin
         if (i_en) valid_q <= tail.valid;
         if (fire) begin
            global_q <= global_d;
            m64_q    <= seg_tail.m64;
            m32_q    <= seg_tail.m32;
            m16_q    <= seg_tail.m16;
            mode_q   <= tail.mode;
            data_q   <= tail.data;
         end
      end
   end

   assign o_valid_max       = valid_q & i_en;
   assign o_global_max      = global_q;
   assign o_max64_0         = m64_q;
   assign o_max32_0         = m32_q[0];
   assign o_max32_1         = m32_q[1];
   assign o_max16_0         = m16_q[0];
   assign o_max16_1         = m16_q[1];
   assign o_max16_2         = m16_q[2];
   assign o_max16_3         = m16_q[3];
   assign o_length_mode_byp = mode_q;
   assign o_in_byp          = data_q;

endmodule

// File: tb/tb_max_tree_module.sv
// Self-checking bench for max_tree_module: directed beats from the feature list
// plus randomized rows, scored against a lane-level reference model.
module tb_max_tree_module;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [3:0]    mode;
   logic [63:0]   valid;
   logic [1023:0] in_flat;

   logic [15:0]   o_global_max, o_max64_0, o_max32_0, o_max32_1;
   logic [15:0]   o_max16_0, o_max16_1, o_max16_2, o_max16_3;
   logic          o_valid_max;
   logic [3:0]    o_length_mode_byp;
   logic [1023:0] o_in_byp;

   max_tree_module dut (
      .i_clk             (clk),
      .i_rst             (rst_n),
      .i_en              (en),
      .i_length_mode     (mode),
      .i_valid           (valid),
      .i_in_flat         (in_flat),
      .o_global_max      (o_global_max),
      .o_max64_0         (o_max64_0),
      .o_max32_0         (o_max32_0),
      .o_max32_1         (o_max32_1),
      .o_max16_0         (o_max16_0),
      .o_max16_1         (o_max16_1),
      .o_max16_2         (o_max16_2),
      .o_max16_3         (o_max16_3),
      .o_valid_max       (o_valid_max),
      .o_length_mode_byp (o_length_mode_byp),
      .o_in_byp          (o_in_byp)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      int                due;
      logic              shown;
      logic [3:0][15:0]  m16;
      logic [1:0][15:0]  m32;
      logic [15:0]       m64;
      logic [3:0]        mode;
      logic [1023:0]     data;
      logic [15:0]       glob;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          en_cnt = 0;
   int          row_cnt = 0;
   logic [3:0]  row_mode = 4'd0;
   logic [15:0] row_run = 16'h8000;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] seg_max(input logic [1023:0] d, input logic [63:0] v,
                                           input int lo, input int cnt);
      int best;
      int x;
      best = -32768;
      for (int k = lo; k < lo + cnt; k++) begin
         x = v[k] ? int'($signed(d[k*16 +: 16])) : -32768;
         if (x > best) best = x;
      end
      return 16'(best);
   endfunction

   // Row accumulator expressed as "beats seen so far in this row".
   function automatic logic [15:0] apply_row(input logic [3:0] m, input logic [15:0] m64);
      if (m < 4'd3) begin
         row_cnt  = 0;
         row_run  = 16'h8000;
         row_mode = m;
         return m64;
      end
      if (row_cnt == 0 || m != row_mode) begin
         row_cnt = 0;
         row_run = m64;
      end else if ($signed(m64) > $signed(row_run)) begin
         row_run = m64;
      end
      row_mode = m;
      row_cnt++;
      if (row_cnt == int'(m) - 1) row_cnt = 0;
      return row_run;
   endfunction

   always @(posedge clk) begin
      if (rst_n && en) begin
         en_cnt++;
         if (valid != 64'd0) begin
            exp_t e;
            e.due   = en_cnt + 12;
            e.shown = 1'b0;
            e.m64   = seg_max(in_flat, valid, 0, 64);
            for (int j = 0; j < 2; j++) e.m32[j] = seg_max(in_flat, valid, 32*j, 32);
            for (int j = 0; j < 4; j++) e.m16[j] = seg_max(in_flat, valid, 16*j, 16);
            e.mode  = mode;
            e.data  = in_flat;
            e.glob  = 16'h0;
            exp_q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         logic exp_v;
         while (exp_q.size() > 0 && exp_q[0].due < en_cnt) begin
            if (!exp_q[0].shown) check_eq("pulse_missing", 256'(0), 256'(1));
            void'(exp_q.pop_front());
         end
         exp_v = (exp_q.size() > 0) && (exp_q[0].due == en_cnt) && en;
         check_eq("valid", 256'(o_valid_max), 256'(exp_v));
         if (exp_v) begin
            e = exp_q[0];
            if (!e.shown) begin
               e.glob  = apply_row(e.mode, e.m64);
               e.shown = 1'b1;
               exp_q[0] = e;
            end
            check_eq("global", 256'(o_global_max), 256'(e.glob));
            check_eq("max64",  256'(o_max64_0), 256'(e.m64));
            check_eq("max32_0", 256'(o_max32_0), 256'(e.m32[0]));
            check_eq("max32_1", 256'(o_max32_1), 256'(e.m32[1]));
            check_eq("max16_0", 256'(o_max16_0), 256'(e.m16[0]));
            check_eq("max16_1", 256'(o_max16_1), 256'(e.m16[1]));
            check_eq("max16_2", 256'(o_max16_2), 256'(e.m16[2]));
            check_eq("max16_3", 256'(o_max16_3), 256'(e.m16[3]));
            check_eq("mode_byp", 256'(o_length_mode_byp), 256'(e.mode));
            for (int c = 0; c < 4; c++)
               check_eq("in_byp", o_in_byp[256*c +: 256], e.data[256*c +: 256]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [1023:0] arith(input int base, input int step);
      logic [1023:0] d;
      for (int k = 0; k < 64; k++) d[k*16 +: 16] = 16'(base + step*k);
      return d;
   endfunction

   function automatic logic [1023:0] rand_lanes();
      logic [1023:0] d;
      for (int k = 0; k < 64; k++) d[k*16 +: 16] = 16'($urandom);
      return d;
   endfunction

   task automatic drive(input logic [3:0] m, input logic [63:0] v, input logic [1023:0] d,
                        input logic e);
      @(posedge clk);
      #1;
      en      = e;
      mode    = m;
      valid   = v;
      in_flat = d;
   endtask

   task automatic idle(input int n, input logic e);
      for (int i = 0; i < n; i++) drive(4'd0, 64'd0, in_flat, e);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_valid"}, 256'(o_valid_max), 256'(0));
      check_eq({tag, "_global"}, 256'(o_global_max), 256'(0));
      check_eq({tag, "_max64"}, 256'(o_max64_0), 256'(0));
      check_eq({tag, "_max16_3"}, 256'(o_max16_3), 256'(0));
      check_eq({tag, "_mode"}, 256'(o_length_mode_byp), 256'(0));
      check_eq({tag, "_byp"}, o_in_byp[255:0], 256'(0));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      row_cnt  = 0;
      row_mode = 4'd0;
      row_run  = 16'h8000;
      @(negedge clk);
      check_zero("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      valid = 64'd0;
   endtask

   // ---------------- stimulus ----------------
   logic [1023:0] d;
   logic [63:0]   ones = {64{1'b1}};

   initial begin
      rst_n   = 1'b0;
      en      = 1'b1;
      mode    = 4'd0;
      valid   = 64'd0;
      in_flat = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single-beat modes.
      drive(4'd0, ones, arith(16'h0100, 0), 1'b1);
      drive(4'd0, ones, arith(10, 10), 1'b1);
      drive(4'd0, ones, arith(16'hFD00, 1), 1'b1);
      drive(4'd2, ones, arith(16'hFF00, 0), 1'b1);
      idle(2, 1'b1);

      // Two consecutive two-beat rows.
      drive(4'd3, ones, arith(16'h0100, 0), 1'b1);
      drive(4'd3, ones, arith(10, 10), 1'b1);
      drive(4'd3, ones, arith(16'hFD00, 1), 1'b1);
      drive(4'd3, ones, arith(16'hFD00, 16), 1'b1);
      idle(2, 1'b1);

      // Seven-beat row whose peak sits in beat six.
      for (int b = 0; b < 5; b++) drive(4'd8, ones, arith(b, 1), 1'b1);
      drive(4'd8, ones, arith(16'h0500, 16), 1'b1);
      drive(4'd8, ones, arith(16'hFF00, 0), 1'b1);
      idle(1, 1'b1);

      // Masked upper half.
      for (int k = 0; k < 64; k++) d[k*16 +: 16] = (k < 32) ? 16'h0001 : 16'h7FFF;
      drive(4'd0, 64'h0000_0000_FFFF_FFFF, d, 1'b1);
      idle(1, 1'b1);

      // Stall mid-flight.
      drive(4'd0, ones, rand_lanes(), 1'b1);
      drive(4'd1, ones, rand_lanes(), 1'b1);
      idle(5, 1'b1);
      drive(4'd0, ones, rand_lanes(), 1'b0);
      idle(2, 1'b0);
      idle(16, 1'b1);

      // Reset while a beat is in the pipe.
      drive(4'd0, ones, arith(16'h0300, 1), 1'b1);
      idle(4, 1'b1);
      do_reset();
      idle(16, 1'b1);

      // Randomized rows, masks and stalls.
      for (int r = 0; r < 60; r++) begin
         logic [3:0] m;
         int         beats;
         m     = 4'($urandom_range(0, 15));
         beats = $urandom_range(1, 6);
         for (int b = 0; b < beats; b++) begin
            logic [63:0] v;
            int          pick;
            pick = $urandom_range(0, 19);
            if (pick == 0)      v = 64'd0;
            else if (pick < 4)  v = {$urandom, $urandom};
            else                v = ones;
            drive(m, v, rand_lanes(), ($urandom_range(0, 9) != 0));
         end
      end
      idle(20, 1'b1);
      check_eq("drain", 256'(exp_q.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
